// File: rtl/riscv32_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv32_common
// Description : Shared memory-port structs, constants and arbiter enums used
//               by the data-memory arbiter and its holding registers.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv32_common;

  // Request towards data memory; vector_data carries the 128-bit vector store.
  typedef struct packed {
    logic         valid;
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [3:0]   do_write;
    logic         is_vector;
    logic [127:0] vector_data;
  } memory_io_req;

  // Response from data memory.
  typedef struct packed {
    logic         valid;
    logic [31:0]  data;
    logic [127:0] vector_data;
  } memory_io_rsp;

  localparam memory_io_req memory_io_no_req = '0;
  localparam memory_io_rsp memory_io_no_rsp = '0;

  typedef enum logic {
    OWN_SCALAR = 1'b0,
    OWN_VECTOR = 1'b1
  } arb_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_RD = 2'd2
  } arb_state_t;

  // The requester that did not win last time.
  function automatic arb_owner_t arb_other(input arb_owner_t o);
    return (o == OWN_SCALAR) ? OWN_VECTOR : OWN_SCALAR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv32_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : riscv32_mem_arbiter_if
// Description : Bundles both requester ports, the memory port and the error
//               pulses of the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv32_mem_arbiter_if;
  import riscv32_common::*;

  memory_io_req scalar_req;
  memory_io_rsp scalar_rsp;
  logic         scalar_busy;
  memory_io_req vector_req;
  memory_io_rsp vector_rsp;
  logic         vector_busy;
  memory_io_req mem_req;
  memory_io_rsp mem_rsp;
  logic         err_overflow;
  logic         err_timeout;

  // Arbiter side.
  modport slave (
    input  scalar_req, vector_req, mem_rsp,
    output scalar_rsp, scalar_busy, vector_rsp, vector_busy,
    output mem_req, err_overflow, err_timeout
  );

  // Requesters and memory side.
  modport master (
    output scalar_req, vector_req, mem_rsp,
    input  scalar_rsp, scalar_busy, vector_rsp, vector_busy,
    input  mem_req, err_overflow, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/riscv32_mem_req_hold.sv
`default_nettype none
// ============================================================================
// Module      : riscv32_mem_req_hold
// Description : One-entry request holding register. Latches a request pulse
//               when empty, drops it and flags overflow when full.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv32_mem_req_hold
  import riscv32_common::*;
(
  input  wire              clk,
  input  wire              reset,
  input  var memory_io_req req_i,
  input  wire              clear_i,
  output logic             valid_o,
  output memory_io_req     data_o,
  output logic             overflow_o
);

  logic         valid_q, valid_d;
  memory_io_req data_q,  data_d;
  logic         ovf_q,   ovf_d;

  // Capture into an empty hold, flag a pulse that hits a full one.
  // clear_i only ever targets a full hold, so it cannot race a capture.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = 1'b0;
    if (req_i.valid) begin
      if (valid_q) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = req_i;
      end
    end
    if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  // Hold state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= memory_io_no_req;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/riscv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv32_mem_arbiter
// Description : Shares the data-memory port between the scalar load/store
//               path and the vector unit; one transaction in flight, read
//               responses routed back to the owner, read timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv32_mem_arbiter
  import riscv32_common::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FIXED_PRIO     = 0
) (
  input  wire                  clk,
  input  wire                  reset,
  riscv32_mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  arb_owner_t       last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic         s_valid, v_valid, s_ovf, v_ovf, clr_s, clr_v, done;
  memory_io_req s_hold, v_hold, sel_hold, mem_req_c;
  memory_io_rsp scalar_rsp_c, vector_rsp_c;
  logic         timeout_c;
  arb_owner_t   grant;

  riscv32_mem_req_hold u_hold_scalar (
    .clk        (clk),
    .reset      (reset),
    .req_i      (bus.scalar_req),
    .clear_i    (clr_s),
    .valid_o    (s_valid),
    .data_o     (s_hold),
    .overflow_o (s_ovf)
  );

  riscv32_mem_req_hold u_hold_vector (
    .clk        (clk),
    .reset      (reset),
    .req_i      (bus.vector_req),
    .clear_i    (clr_v),
    .valid_o    (v_valid),
    .data_o     (v_hold),
    .overflow_o (v_ovf)
  );

  // Arbitration, issue and read-wait sequencing with response routing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    grant        = OWN_SCALAR;
    done         = 1'b0;
    mem_req_c    = memory_io_no_req;
    scalar_rsp_c = memory_io_no_rsp;
    vector_rsp_c = memory_io_no_rsp;
    timeout_c    = 1'b0;
    sel_hold     = (owner_q == OWN_SCALAR) ? s_hold : v_hold;

    case (state_q)
      ARB_IDLE: begin
        if (s_valid || v_valid) begin
          if (s_valid && v_valid) begin
            grant = (FIXED_PRIO != 0) ? OWN_SCALAR : arb_other(last_q);
          end else begin
            grant = s_valid ? OWN_SCALAR : OWN_VECTOR;
          end
          owner_d = grant;
          last_d  = grant;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req_c       = sel_hold;
        mem_req_c.valid = 1'b1;
        if (sel_hold.do_write != 4'd0) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ARB_WAIT_RD;
        end
      end
      ARB_WAIT_RD: begin
        if (bus.mem_rsp.valid) begin
          if (owner_q == OWN_SCALAR) begin
            scalar_rsp_c = bus.mem_rsp;
          end else begin
            vector_rsp_c = bus.mem_rsp;
          end
          done    = 1'b1;
          state_d = ARB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_c = 1'b1;
          done      = 1'b1;
          state_d   = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    clr_s = done && (owner_q == OWN_SCALAR);
    clr_v = done && (owner_q == OWN_VECTOR);
  end

  // Arbiter state registers; last grant starts at vector so scalar wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_SCALAR;
      last_q  <= OWN_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_req      = mem_req_c;
  assign bus.scalar_rsp   = scalar_rsp_c;
  assign bus.vector_rsp   = vector_rsp_c;
  assign bus.scalar_busy  = s_valid;
  assign bus.vector_busy  = v_valid;
  assign bus.err_overflow = s_ovf | v_ovf;
  assign bus.err_timeout  = timeout_c;

endmodule
`default_nettype wire

// File: doc/riscv32_mem_arbiter.md
Name: riscv32_mem_arbiter

Overview:
Shares the single unified data-memory port between the scalar core load/store path and the vector unit. Each requester issues one-cycle request pulses. The arbiter buffers each pulse in a one-entry holding register, grants the memory port round-robin, and keeps at most one transaction in flight. Read responses are routed back to whichever requester owns the transaction. The block sits between both requesters and the data memory.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles to wait for a read response before the transaction is abandoned.
FIXED_PRIO, 0, arbitration mode: 0 = round-robin; 1 = scalar always wins.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
scalar_req  input  memory_io_req  scalar request; valid is a one-cycle pulse
scalar_rsp  output  memory_io_rsp  response to scalar
scalar_busy  output  1  scalar hold full; scalar must not assert valid
vector_req  input  memory_io_req  vector request (is_vector=1, vector_data for stores)
vector_rsp  output  memory_io_rsp  response to vector
vector_busy  output  1  vector hold full
mem_req  output  memory_io_req  to data memory
mem_rsp  input  memory_io_rsp  from data memory
err_overflow  output  1  one-cycle pulse: a request arrived while its hold was full
err_timeout  output  1  one-cycle pulse: a read was abandoned

Behaviour:
- Reset (sync, active-high):
  - Both holds empty, state ARB_IDLE, timeout counter 0, last_grant = OWN_VECTOR, so scalar wins the first tie.
  - mem_req = memory_io_no_req; scalar_rsp and vector_rsp all-zero; busy outputs 0; error outputs 0.
  - Reset mid-transaction discards all state. A mem_rsp arriving after reset is ignored.
- Capture:
  - req.valid with hold empty: the full struct is latched at the edge; busy = 1 from the next cycle.
  - req.valid with hold full: the request is dropped, the hold is unchanged, err_overflow pulses next cycle.
- State ARB_IDLE:
  - If any hold is valid, select the owner and go to ARB_ISSUE at the next edge.
  - Both valid: FIXED_PRIO=0 grants the requester that is not last_grant; FIXED_PRIO=1 grants scalar.
  - last_grant is updated at the grant.
- State ARB_ISSUE (exactly one cycle):
  - mem_req = the owner's hold contents, with valid=1.
  - Write (do_write != 0): clear the owner's hold, go to ARB_IDLE. No response is generated.
  - Read: go to ARB_WAIT_RD and clear the counter.
- State ARB_WAIT_RD:
  - mem_req = no_req.
  - On mem_rsp.valid: pass mem_rsp combinationally to the owner's rsp port in the same cycle. The other rsp port stays zero. Clear the owner's hold, go to ARB_IDLE.
  - Otherwise increment the counter. At TIMEOUT_CYCLES-1: pulse err_timeout, clear the hold, go to ARB_IDLE. No response is delivered.
- mem_rsp.valid in ARB_IDLE or ARB_ISSUE is ignored and never forwarded.
- Latency:
  - Requester valid in cycle N → mem_req.valid in cycle N+2 (uncontended).
  - Read response forwarded in the same cycle it arrives.
  - busy deasserts the cycle after the hold clears.
  - Minimum back-to-back issue spacing is 2 cycles.
- Holds are not cleared by capture; a new capture is accepted in the same cycle busy reads 0.
- The timeout counter width is $clog2(TIMEOUT_CYCLES)+1 and the counter does not wrap.

Decomposition:
- Shared package (riscv32_common): arb_owner_t {OWN_SCALAR, OWN_VECTOR}, arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD}, and a memory_io_no_rsp constant if not already present.
- Sub-module riscv32_mem_req_hold: one-entry holding register with load, clear, valid and overflow. Instantiated twice.

Test Plan:
- Scalar read at addr 0x100, alone: mem_req.valid in cycle N+2 with addr=0x100; memory answers data=0xDEADBEEF three cycles later → scalar_rsp.valid=1, data=0xDEADBEEF in that same cycle; vector_rsp stays zero; scalar_busy clears next cycle.
- Scalar read 0x200 and vector load 0x300 in the same cycle, FIXED_PRIO=0, after reset: scalar issued first. After its response, vector issued at 0x300 and its response (vector_data=128'h1) appears on vector_rsp only.
- Vector store to 0x400 with vector_data=128'h0000_0004_0000_0003_0000_0002_0000_0001: mem_req has is_vector=1, do_write=4'b1111, matching data, for exactly one cycle. State back to ARB_IDLE the next cycle; no rsp on either port.
- Second scalar request while scalar_busy=1: err_overflow pulses once. The first request completes normally; the second never appears on mem_req.
- Read with no memory response: err_timeout pulses after 64 cycles in ARB_WAIT_RD, scalar_busy clears. A late mem_rsp.valid is not forwarded.
- Reset asserted during ARB_WAIT_RD: next cycle mem_req.valid=0, both busy=0, and a subsequent mem_rsp.valid is ignored.
